// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FSM states, default field widths and special-value patterns for the FP add/sub unit
package fpu_pkg;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int DEF_GRS_W = 3;
  localparam int DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;

  // Patterns are built at this fixed width and sliced down by the user.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] inf_bits(input logic sign, input int exp_w, input int man_w);
    logic [MAX_W-1:0] r;
    r = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
    r = r | (MAX_W'(sign) << (exp_w + man_w));
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
    logic [MAX_W-1:0] r;
    r = inf_bits(1'b0, exp_w, man_w);
    r = r | (MAX_W'(1) << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - combinational leading-zero counter; an all-zero input reports N
module fpu_lzc #(
  parameter int N  = 27,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  x,
  output logic [CW-1:0] cnt
);

  logic found;

  always_comb begin
    cnt   = CW'(N);
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        cnt   = CW'(N - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_mc.sv
// rtl/fpu_addsub_mc.sv - multi-cycle RNE floating-point add/subtract, fixed latency
module fpu_addsub_mc
  import fpu_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int GRS_W = DEF_GRS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   c,
  output logic                   zero,
  output logic                   ovf,
  output logic                   inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int AW = MAN_W + 1 + GRS_W;
  localparam int NW = AW + 1;
  localparam int LW = $clog2(NW + 1);
  localparam int XW = EXP_W + 2;

  localparam logic [MAX_W-1:0] QNAN_FULL = qnan_bits(EXP_W, MAN_W);
  localparam logic [MAX_W-1:0] INF_FULL  = inf_bits(1'b0, EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];
  localparam logic [W-2:0]     INF_MAG   = INF_FULL[W-2:0];
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [EXP_W:0]   SHIFT_LIM = (EXP_W + 1)'(AW);
  localparam logic [XW-1:0]    EXP_OVF   = XW'((1 << EXP_W) - 1);

  state_t state;

  logic [W-1:0]  a_q, b_q;
  logic          op_q;
  logic          sign_r, sub_r, spec_r, zero_r;
  logic [W-1:0]  spec_val_r;
  logic [XW-1:0] exp_r;
  logic [AW-1:0] big_r, small_r, nm_r;
  logic [NW-1:0] sum_r;
  logic [W-1:0]  res_r;
  logic          zf_r, of_r, ix_r;

  // Operand unpack; B's sign already folds in the subtract request.
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  assign {sa, ea, ma} = a_q;
  assign {eb, mb}     = b_q[W-2:0];
  assign sb           = b_q[W-1] ^ op_q;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, any_nan;
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (ea == EXP_ONES) && (ma == '0);
  assign b_inf   = (eb == EXP_ONES) && (mb == '0);
  assign a_nan   = (ea == EXP_ONES) && (ma != '0);
  assign b_nan   = (eb == EXP_ONES) && (mb != '0);
  assign any_nan = a_nan || b_nan || (a_inf && b_inf && (sa != sb));

  logic [W-2:0]     mag_a, mag_b;
  logic             a_big;
  logic [SW-1:0]    sig_a, sig_b, s_big, s_small;
  logic [EXP_W-1:0] e_big, e_small, diff;
  assign mag_a   = a_zero ? '0 : {ea, ma};
  assign mag_b   = b_zero ? '0 : {eb, mb};
  assign a_big   = (mag_a >= mag_b);
  assign sig_a   = a_zero ? '0 : {1'b1, ma};
  assign sig_b   = b_zero ? '0 : {1'b1, mb};
  assign s_big   = a_big ? sig_a : sig_b;
  assign s_small = a_big ? sig_b : sig_a;
  assign e_big   = a_big ? ea : eb;
  assign e_small = a_big ? eb : ea;
  assign diff    = e_big - e_small;

  logic [AW-1:0] ext, lost, small_al;
  assign ext = {s_small, {GRS_W{1'b0}}};

  always_comb begin
    lost     = '0;
    small_al = '0;
    if ({1'b0, diff} >= SHIFT_LIM) begin
      small_al = {{(AW-1){1'b0}}, |ext};
    end else begin
      lost     = ext & ~({AW{1'b1}} << diff);
      small_al = (ext >> diff) | {{(AW-1){1'b0}}, |lost};
    end
  end

  logic [NW-1:0] sum_n;
  assign sum_n = sub_r ? ({1'b0, big_r} - {1'b0, small_r}) : ({1'b0, big_r} + {1'b0, small_r});

  // Without a carry the MSB is zero, so the leading one moves up by lz-1.
  logic [LW-1:0] lz, sh;
  fpu_lzc #(.N(NW), .CW(LW)) u_lzc (.x(sum_r), .cnt(lz));
  assign sh = lz - LW'(1);

  logic [AW-1:0] nm_n;
  logic [XW-1:0] exp_n;
  logic          zero_n, sign_n;

  always_comb begin
    nm_n   = '0;
    exp_n  = exp_r;
    zero_n = 1'b0;
    sign_n = sign_r;
    if (sum_r == '0) begin
      zero_n = 1'b1;
      exp_n  = '0;
      if (sub_r) sign_n = 1'b0;
    end else if (sum_r[NW-1]) begin
      nm_n  = {sum_r[NW-1:2], sum_r[1] | sum_r[0]};
      exp_n = exp_r + XW'(1);
    end else begin
      nm_n  = AW'(sum_r << sh);
      exp_n = exp_r - XW'(sh);
    end
    if (!zero_n && (exp_n[XW-1] || exp_n == '0)) begin
      zero_n = 1'b1;
      nm_n   = '0;
      exp_n  = '0;
    end
  end

  logic [SW-1:0]    mant;
  logic             g_bit, rs_bits, inc;
  logic [SW:0]      rnd;
  logic [XW-1:0]    exp_f;
  logic [MAN_W-1:0] man_f;
  assign mant    = nm_r[AW-1:GRS_W];
  assign g_bit   = nm_r[GRS_W-1];
  assign rs_bits = |nm_r[GRS_W-2:0];
  assign inc     = g_bit & (rs_bits | mant[0]);
  assign rnd     = {1'b0, mant} + (SW + 1)'(inc);
  assign exp_f   = exp_r + XW'(rnd[SW]);
  assign man_f   = rnd[SW] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      c       <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      inexact <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= ALIGN;
          busy    <= 1'b1;
          zero    <= 1'b0;
          ovf     <= 1'b0;
          inexact <= 1'b0;
        end
        ALIGN: state <= ADD;
        ADD:   state <= NORM;
        NORM:  state <= ROUND;
        ROUND: state <= DONE;
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          c       <= res_r;
          zero    <= zf_r;
          ovf     <= of_r;
          inexact <= ix_r;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      ALIGN: begin
        sign_r     <= a_big ? sa : sb;
        sub_r      <= sa ^ sb;
        exp_r      <= {2'b00, e_big};
        big_r      <= {s_big, {GRS_W{1'b0}}};
        small_r    <= small_al;
        spec_r     <= any_nan || a_inf || b_inf;
        spec_val_r <= any_nan ? QNAN : (a_inf ? {sa, INF_MAG} : {sb, INF_MAG});
      end
      ADD: sum_r <= sum_n;
      NORM: begin
        nm_r   <= nm_n;
        exp_r  <= exp_n;
        sign_r <= sign_n;
        zero_r <= zero_n;
      end
      ROUND: begin
        zf_r <= 1'b0;
        of_r <= 1'b0;
        ix_r <= 1'b0;
        if (spec_r) begin
          res_r <= spec_val_r;
        end else if (zero_r) begin
          res_r <= {sign_r, {(W-1){1'b0}}};
          zf_r  <= 1'b1;
        end else if (exp_f >= EXP_OVF) begin
          res_r <= {sign_r, INF_MAG};
          of_r  <= 1'b1;
          ix_r  <= g_bit | rs_bits;
        end else begin
          res_r <= {sign_r, exp_f[EXP_W-1:0], man_f};
          ix_r  <= g_bit | rs_bits;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpu_addsub_mc.sv
// tb/tb_fpu_addsub_mc.sv - directed self-checking bench for fpu_addsub_mc (single precision)
module tb_fpu_addsub_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, zero, ovf, inexact;
  logic [31:0] c;

  int errors = 0;
  int checks = 0;
  int lat;
  int busy_cnt, done_cnt;
  logic [31:0] c_at_done;

  fpu_addsub_mc #(.EXP_W(8), .MAN_W(23), .GRS_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .zero(zero), .ovf(ovf), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns the number of rising edges after the accepting edge until done is seen.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xop, output int n);
    @(negedge clk);
    a = xa; b = xb; op = xop; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic op_chk(input string tag, input logic [31:0] xa, input logic [31:0] xb, input logic xop,
                        input logic [31:0] ec, input logic ez, input logic eo, input logic ei);
    int n;
    run_op(xa, xb, xop, n);
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_c"}, c, ec);
    chk({tag, "_flags"}, {29'd0, zero, ovf, inexact}, {29'd0, ez, eo, ei});
  endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctl", {28'd0, busy, done, zero, ovf}, 32'd0);
    chk("reset_c", c, 32'h0);
    chk("reset_inexact", {31'd0, inexact}, 32'd0);
    rst = 1'b0;

    op_chk("add_1p5_2p5", 32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);

    op_chk("sub_3_5", 32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 1'b0, 1'b0, 1'b0);
    op_chk("sub_cancel", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0);
    op_chk("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1);
    op_chk("tie_odd", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1);
    op_chk("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b0);
    op_chk("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b0);
    op_chk("nan_in", 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b0);
    op_chk("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0, 1'b0);
    op_chk("neg_zero_cancel", 32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);

    // A second start two cycles into an operation must be ignored.
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40200000; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = done ? 1 : 0;
    c_at_done = 32'hDEADBEEF;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin
        a = 32'h40400000; b = 32'h40A00000; op = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        c_at_done = c;
      end
    end
    start = 1'b0;
    chk("ignored_busy_cycles", busy_cnt, 5);
    chk("ignored_done_count", done_cnt, 1);
    chk("ignored_result", c_at_done, 32'h40800000);

    // Asynchronous reset while the operation sits in NORM.
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40200000; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_ctl", {28'd0, busy, done, zero, ovf}, 32'd0);
    chk("async_reset_c", c, 32'h0);
    chk("async_reset_inexact", {31'd0, inexact}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op_chk("after_reset", 32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
